// File: rtl/encoder_block_3to8.sv
// encoder_block_3to8: APB read-only slave returning a one-hot encoding of the transfer address
module encoder_block_3to8 (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       pwrite,
    input  logic       psel,
    input  logic       penable,
    input  logic [7:0] paddr,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t     state;
    logic [7:0] addr;
    logic       wr;
    logic       err;
    // full 8-bit decode: anything above 7 is an error, never an alias
    assign err = wr || (addr[7:3] != 5'd0);
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state   <= IDLE;
            addr    <= 8'h00;
            wr      <= 1'b0;
            prdata  <= 8'h00;
            pready  <= 1'b0;
            pslverr <= 1'b0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            case (state)
                IDLE: if (psel && !penable) begin
                    state <= SETUP;
                    addr  <= paddr;
                    wr    <= pwrite;
                end
                SETUP: if (!psel) begin
                    state <= IDLE;
                end else if (penable) begin
                    state   <= ACCESS;
                    pready  <= 1'b1;
                    pslverr <= err;
                    prdata  <= err ? 8'h00 : 8'h01 << addr[2:0];
                end else begin
                    addr <= paddr;
                    wr   <= pwrite;
                end
                ACCESS: if (psel && !penable) begin
                    state <= SETUP;
                    addr  <= paddr;
                    wr    <= pwrite;
                end else begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_encoder_block_3to8.sv
// tb_encoder_block_3to8: vector table, hand-written corner sequences and random reads/writes vs a reference model
module tb_encoder_block_3to8;
    logic       pclk = 1'b0;
    logic       preset_n = 1'b0;
    logic       pwrite = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    int         checks = 0;
    int         errors = 0;

    encoder_block_3to8 dut (
        .pclk(pclk), .preset_n(preset_n), .pwrite(pwrite), .psel(psel),
        .penable(penable), .paddr(paddr), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {err, data}: reads of 0..7 give bit number addr set, everything else is an error with zero data
    function automatic logic [8:0] model(input logic [7:0] a, input logic w);
        if (w || a >= 8) return {1'b1, 8'h00};
        return {1'b0, 8'(2 ** a)};
    endfunction

    // setup edge, then penable held high for four edges; exactly one pulse expected, right after E1
    task automatic run(input string name, input logic [7:0] a, input logic w,
                       input logic [7:0] exp_d, input logic exp_e);
        int pulses = 0;
        int first = -1;
        logic [7:0] d = 8'h00;
        logic e = 1'b0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w;
        @(posedge pclk); #1;
        chk({name, "_setup_pready"}, pready, 0);
        penable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge pclk); #1;
            if (pready) begin
                if (first < 0) first = k;
                pulses++;
                d = prdata;
                e = pslverr;
            end else if (pslverr !== 1'b0) begin
                chk({name, "_pslverr_idle"}, pslverr, 0);
            end
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk({name, "_pulses"}, pulses, 1);
        chk({name, "_latency"}, first, 0);
        chk({name, "_prdata"}, d, exp_d);
        chk({name, "_pslverr"}, e, exp_e);
        chk({name, "_hold"}, prdata, exp_d);
    endtask

    initial begin
        vec_t vecs[$];
        logic [7:0] prev;
        logic [8:0] m;
        logic [7:0] ra;
        logic rw;
        int p;
        vecs = '{
            '{8'd0, 1'b0, 8'h01, 1'b0}, '{8'd1, 1'b0, 8'h02, 1'b0},
            '{8'd2, 1'b0, 8'h04, 1'b0}, '{8'd3, 1'b0, 8'h08, 1'b0},
            '{8'd4, 1'b0, 8'h10, 1'b0}, '{8'd5, 1'b0, 8'h20, 1'b0},
            '{8'd6, 1'b0, 8'h40, 1'b0}, '{8'd7, 1'b0, 8'h80, 1'b0},
            '{8'd8, 1'b0, 8'h00, 1'b1}, '{8'hFF, 1'b0, 8'h00, 1'b1},
            '{8'd3, 1'b0, 8'h08, 1'b0}, '{8'd2, 1'b1, 8'h00, 1'b1},
            '{8'd2, 1'b0, 8'h04, 1'b0}, '{8'd10, 1'b0, 8'h00, 1'b1},
            '{8'd7, 1'b1, 8'h00, 1'b1}, '{8'd7, 1'b0, 8'h80, 1'b0}
        };
        #2;
        chk("reset_prdata", prdata, 8'h00);
        chk("reset_pready", pready, 0);
        chk("reset_pslverr", pslverr, 0);
        #10 preset_n = 1'b1;

        foreach (vecs[i]) run("vec", vecs[i].addr, vecs[i].wr, vecs[i].exp_data, vecs[i].exp_err);

        // asynchronous reset mid-cycle after a non-zero read
        run("pre_rst", 8'd6, 1'b0, 8'h40, 1'b0);
        #3 preset_n = 1'b0;
        #1;
        chk("async_rst_prdata", prdata, 8'h00);
        chk("async_rst_pready", pready, 0);
        chk("async_rst_pslverr", pslverr, 0);
        #2 preset_n = 1'b1;

        // back-to-back: next setup sampled on the edge that ends the pready cycle
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 8'd5; pwrite = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        chk("b2b_first_pready", pready, 1);
        chk("b2b_first_prdata", prdata, 8'h20);
        chk("b2b_first_pslverr", pslverr, 0);
        penable = 1'b0; paddr = 8'd1;
        @(posedge pclk); #1;
        chk("b2b_setup_pready", pready, 0);
        penable = 1'b1;
        @(posedge pclk); #1;
        chk("b2b_second_pready", pready, 1);
        chk("b2b_second_prdata", prdata, 8'h02);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        chk("b2b_end_pready", pready, 0);

        // psel dropped during setup: silent cancel
        prev = prdata;
        psel = 1'b1; paddr = 8'd6;
        @(posedge pclk); #1;
        psel = 1'b0;
        p = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            if (pready) p++;
        end
        chk("cancel_pulses", p, 0);
        chk("cancel_prdata", prdata, prev);

        // reset during access kills the pulse
        psel = 1'b1; penable = 1'b0; paddr = 8'd6;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        chk("acc_rst_pready_before", pready, 1);
        #2 preset_n = 1'b0;
        #1;
        chk("acc_rst_pready", pready, 0);
        chk("acc_rst_prdata", prdata, 8'h00);
        psel = 1'b0; penable = 1'b0;
        #2 preset_n = 1'b1;
        run("after_rst", 8'd4, 1'b0, 8'h10, 1'b0);

        // random traffic, addresses biased toward the legal range
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
            rw = ($urandom_range(0, 4) == 0);
            m = model(ra, rw);
            run("rand", ra, rw, m[7:0], m[8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
